sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares one SDRAM controller command port among NPORTS requesters, e.g. test-pattern writer, verifier and video readout.
- Sits between the requesters and the SDRAM controller inside the SDRAM stress-test core, in the clk_sys domain.
- Port 0 has fixed high priority, with a starvation override for the other ports. Ports 1..NPORTS-1 are served round-robin.
- Read data is returned to its issuing port through an in-order tag FIFO.

Parameters:
- NPORTS, 3: number of requester ports (2..8).
- AW, 25: word address width.
- DW, 16: data width.
- RD_DEPTH, 4: maximum outstanding reads (tag FIFO depth, power of 2).
- STARVE_LIMIT, 64: cycles a pending low-priority request may wait before it is forced to win.

Ports:
- clk_sys  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NPORTS  per-port request valid.
- req_we  in  NPORTS  per-port 1=write, 0=read.
- req_addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW].
- req_wdata  in  NPORTS*DW  per-port write data, same packing.
- req_ready  out  NPORTS  one-hot accept strobe.
- rsp_valid  out  NPORTS  one-hot read-data strobe.
- rsp_data  out  DW  read data, shared by all ports.
- ctl_valid  out  1  command valid to controller.
- ctl_ready  in  1  controller accepts command.
- ctl_we  out  1  command is a write.
- ctl_addr  out  AW  command address.
- ctl_wdata  out  DW  command write data.
- ctl_rdata_valid  in  1  controller read data strobe, in issue order.
- ctl_rdata  in  DW  controller read data.
- grant_id  out  3  port of the command currently in ctl_*.
- rd_pending  out  $clog2(RD_DEPTH)+1  outstanding read count.
- err_orphan  out  1  sticky: read data arrived with no outstanding tag.

Behaviour:
- Reset values: req_ready, rsp_valid, ctl_valid, ctl_we, grant_id, rd_pending and err_orphan are 0; ctl_addr, ctl_wdata and rsp_data are 0.
  - Tag FIFO is emptied, the round-robin pointer is set to port 1 and all starvation counters are 0.
- Reset mid-operation: the pending command and outstanding tags are dropped, and no rsp_valid is produced for them. The controller is reset in the same cycle by the system.
- Slot free: ctl_valid==0, or ctl_valid&&ctl_ready this cycle.
- Eligibility: port i is eligible when req_valid[i] and (req_we[i], or a read tag is available).
  - A read tag is available when rd_pending<RD_DEPTH, or a pop occurs this cycle.
- Arbitration (combinational, only while the slot is free), first match wins:
  1. The lowest-index port i>=1 with starve_cnt[i]==STARVE_LIMIT and eligible.
  2. Port 0 if eligible.
  3. Round-robin among eligible ports 1..NPORTS-1, starting at the pointer.
- Grant:
  - req_ready[winner]=1 for that cycle only; req_ready is 0 when the slot is not free.
  - The request is accepted on req_valid&&req_ready.
- Next cycle after a grant:
  - ctl_valid=1 and ctl_we/addr/wdata/grant_id are registered from the winner. Accept-to-ctl_valid latency is 1 cycle.
  - ctl_* stay stable until ctl_ready.
  - If there is no winner and the slot is free, ctl_valid goes to 0.
- Back-to-back: a new winner may be accepted in the same cycle ctl_ready fires, sustaining 1 command per cycle.
- Round-robin pointer: when a port >=1 wins by either rule, the pointer moves to winner+1, wrapping from NPORTS-1 to 1.
- Starvation counters:
  - starve_cnt[i] (i>=1) increments each cycle req_valid[i]&&!req_ready[i], saturating at STARVE_LIMIT.
  - It clears when req_ready[i] fires or req_valid[i]==0.
- Tag FIFO:
  - Push grant_id when a read is accepted (req_ready on a read).
  - Pop on ctl_rdata_valid. A push and a pop in the same cycle leave the count unchanged.
  - Full FIFO blocks only reads, never writes.
- Response:
  - On ctl_rdata_valid with the FIFO non-empty, next cycle rsp_valid[head]=1 and rsp_data=ctl_rdata (1-cycle latency).
  - With the FIFO empty: no rsp_valid, err_orphan is set and stays set until reset.
- Requesters must hold req_* stable while req_valid && !req_ready.

Test Plan:
- Single write: port 1 write addr 0x0000100, data 0xA5A5, ctl_ready=1 -> req_ready[1] at cycle 0; ctl_valid, ctl_we=1, ctl_addr=0x100, ctl_wdata=0xA5A5, grant_id=1 at cycle 1 only.
- Round-robin: ports 1 and 2 reading continuously, port 0 idle, controller returning data 2 cycles after each command -> grants alternate 1,2,1,2.
  - Each rsp_valid lands on the issuing port in order.
  - rd_pending never exceeds 4.
- Priority and starvation: port 0 writing continuously, port 2 read pending, STARVE_LIMIT=64 -> port 2 granted exactly once after 64 wait cycles, then port 0 resumes.
- Tag full: 4 reads issued with no data returned -> a 5th read from port 1 is not granted, while a write from port 2 is granted.
  - One ctl_rdata_valid -> the port 1 read is granted in that same cycle.
- Backpressure: ctl_ready=0 for 10 cycles with ctl_valid=1 -> ctl_* stable and req_ready all 0; on release, the next command is accepted in the same cycle.
- Orphan and reset: ctl_rdata_valid with rd_pending=0 -> err_orphan=1 and no rsp_valid.
  - reset pulse with 2 reads outstanding -> rd_pending=0, err_orphan=0, and no rsp_valid for the 2 dropped reads.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among NPORTS requesters: port 0 has fixed
// priority, ports 1..N-1 rotate, and starved ports are forced through. Read data is routed back in order.
module sdram_port_arbiter #(
    parameter int unsigned NPORTS       = 3,
    parameter int unsigned AW           = 25,
    parameter int unsigned DW           = 16,
    parameter int unsigned RD_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [NPORTS-1:0]         req_valid,
    input  logic [NPORTS-1:0]         req_we,
    input  logic [NPORTS*AW-1:0]      req_addr,
    input  logic [NPORTS*DW-1:0]      req_wdata,
    output logic [NPORTS-1:0]         req_ready,
    output logic [NPORTS-1:0]         rsp_valid,
    output logic [DW-1:0]             rsp_data,
    output logic                      ctl_valid,
    input  logic                      ctl_ready,
    output logic                      ctl_we,
    output logic [AW-1:0]             ctl_addr,
    output logic [DW-1:0]             ctl_wdata,
    input  logic                      ctl_rdata_valid,
    input  logic [DW-1:0]             ctl_rdata,
    output logic [2:0]                grant_id,
    output logic [$clog2(RD_DEPTH):0] rd_pending,
    output logic                      err_orphan
);

    localparam int unsigned IDW = 3;
    localparam int unsigned RAW = $clog2(RD_DEPTH);
    localparam int unsigned CW  = RAW + 1;
    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);

    logic              ctl_valid_q, ctl_valid_d;
    logic              ctl_we_q, ctl_we_d;
    logic [AW-1:0]     ctl_addr_q, ctl_addr_d;
    logic [DW-1:0]     ctl_wdata_q, ctl_wdata_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     starve_q [1:NPORTS-1];
    logic [SW-1:0]     starve_d [1:NPORTS-1];
    logic [IDW-1:0]    tag_mem_q [RD_DEPTH];
    logic [IDW-1:0]    tag_mem_d [RD_DEPTH];
    logic [RAW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [RAW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              err_orphan_q, err_orphan_d;

    logic              slot_free_c;
    logic              pop_c;
    logic              push_c;
    logic              tag_avail_c;
    logic [NPORTS-1:0] eligible_c;
    logic              win_found_c;
    logic [IDW-1:0]    win_id_c;
    logic              win_we_c;
    logic [AW-1:0]     win_addr_c;
    logic [DW-1:0]     win_wdata_c;
    logic [IDW-1:0]    head_id_c;

    // Arbitration: starvation override, then port 0, then round-robin from the pointer.
    always_comb begin
        slot_free_c = !ctl_valid_q || ctl_ready;
        pop_c       = ctl_rdata_valid && (count_q != '0);
        tag_avail_c = (count_q < CW'(RD_DEPTH)) || pop_c;
        eligible_c  = req_valid & (req_we | {NPORTS{tag_avail_c}});
        win_found_c = 1'b0;
        win_id_c    = '0;
        if (slot_free_c) begin
            for (int unsigned i = 1; i < NPORTS; i++) begin
                if (!win_found_c && eligible_c[i] && (starve_q[i] == SW'(STARVE_LIMIT))) begin
                    win_found_c = 1'b1;
                    win_id_c    = IDW'(i);
                end
            end
            if (!win_found_c && eligible_c[0]) begin
                win_found_c = 1'b1;
                win_id_c    = '0;
            end
            for (int unsigned i = 1; i < NPORTS; i++) begin
                if (!win_found_c && eligible_c[i] && (IDW'(i) >= rr_ptr_q)) begin
                    win_found_c = 1'b1;
                    win_id_c    = IDW'(i);
                end
            end
            // Wrap-around pass: nothing at or above the pointer was eligible.
            for (int unsigned i = 1; i < NPORTS; i++) begin
                if (!win_found_c && eligible_c[i]) begin
                    win_found_c = 1'b1;
                    win_id_c    = IDW'(i);
                end
            end
        end

        req_ready   = '0;
        win_we_c    = 1'b0;
        win_addr_c  = '0;
        win_wdata_c = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            req_ready[i] = win_found_c && (win_id_c == IDW'(i));
            if (win_id_c == IDW'(i)) begin
                win_we_c    = req_we[i];
                win_addr_c  = req_addr[i*AW +: AW];
                win_wdata_c = req_wdata[i*DW +: DW];
            end
        end
        push_c    = win_found_c && !win_we_c;
        head_id_c = tag_mem_q[rd_ptr_q];
    end

    // Next-state for command register, pointer, starvation counters, tag FIFO and response.
    always_comb begin
        ctl_valid_d = ctl_valid_q;
        ctl_we_d    = ctl_we_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_wdata_d = ctl_wdata_q;
        grant_id_d  = grant_id_q;
        if (slot_free_c) begin
            ctl_valid_d = win_found_c;
            if (win_found_c) begin
                ctl_we_d    = win_we_c;
                ctl_addr_d  = win_addr_c;
                ctl_wdata_d = win_wdata_c;
                grant_id_d  = win_id_c;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (win_found_c && (win_id_c != '0)) begin
            rr_ptr_d = (win_id_c == IDW'(NPORTS - 1)) ? IDW'(1) : win_id_c + IDW'(1);
        end

        for (int unsigned i = 1; i < NPORTS; i++) begin
            starve_d[i] = '0;
            if (req_valid[i] && !req_ready[i]) begin
                starve_d[i] = (starve_q[i] == SW'(STARVE_LIMIT)) ? starve_q[i]
                                                                 : starve_q[i] + SW'(1);
            end
        end

        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_c) begin
            tag_mem_d[wr_ptr_q] = win_id_c;
            wr_ptr_d            = wr_ptr_q + RAW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + RAW'(1);
        end
        count_d = count_q + CW'(push_c) - CW'(pop_c);

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pop_c) begin
            rsp_data_d = ctl_rdata;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                rsp_valid_d[i] = (head_id_c == IDW'(i));
            end
        end
        err_orphan_d = err_orphan_q || (ctl_rdata_valid && (count_q == '0));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ctl_valid_q  <= 1'b0;
            ctl_we_q     <= 1'b0;
            ctl_addr_q   <= '0;
            ctl_wdata_q  <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= IDW'(1);
            for (int unsigned i = 1; i < NPORTS; i++) begin
                starve_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            ctl_valid_q  <= ctl_valid_d;
            ctl_we_q     <= ctl_we_d;
            ctl_addr_q   <= ctl_addr_d;
            ctl_wdata_q  <= ctl_wdata_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int unsigned i = 1; i < NPORTS; i++) begin
                starve_q[i] <= starve_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_sys) begin
        tag_mem_q <= tag_mem_d;
    end

    assign ctl_valid  = ctl_valid_q;
    assign ctl_we     = ctl_we_q;
    assign ctl_addr   = ctl_addr_q;
    assign ctl_wdata  = ctl_wdata_q;
    assign grant_id   = grant_id_q;
    assign rd_pending = count_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: write path, round-robin reads, starvation,
// tag-full blocking, backpressure, orphan data and mid-operation reset.
module tb_sdram_port_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 16;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic [NP-1:0]      req_valid;
    logic [NP-1:0]      req_we;
    logic [NP*AW-1:0]   req_addr;
    logic [NP*DW-1:0]   req_wdata;
    logic [NP-1:0]      req_ready;
    logic [NP-1:0]      rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               ctl_valid;
    logic               ctl_ready;
    logic               ctl_we;
    logic [AW-1:0]      ctl_addr;
    logic [DW-1:0]      ctl_wdata;
    logic               ctl_rdata_valid;
    logic [DW-1:0]      ctl_rdata;
    logic [2:0]         grant_id;
    logic [2:0]         rd_pending;
    logic               err_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_port_arbiter #(
        .NPORTS(NP), .AW(AW), .DW(DW), .RD_DEPTH(4), .STARVE_LIMIT(64)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_we(ctl_we),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_rdata_valid(ctl_rdata_valid), .ctl_rdata(ctl_rdata),
        .grant_id(grant_id), .rd_pending(rd_pending), .err_orphan(err_orphan)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p]          = v;
        req_we[p]             = we;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        req_valid       = '0;
        req_we          = '0;
        req_addr        = '0;
        req_wdata       = '0;
        ctl_ready       = 1'b0;
        ctl_rdata_valid = 1'b0;
        ctl_rdata       = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic        rdv [0:63];
    logic [15:0] rdd [0:63];
    int          exp_q [$];
    int          n_rsp;
    int          exp_p;

    initial begin
        do_reset();
        // Reset state
        check("rst_ctl_valid", 32'(ctl_valid), 0);
        check("rst_ctl_we", 32'(ctl_we), 0);
        check("rst_ctl_addr", 32'(ctl_addr), 0);
        check("rst_ctl_wdata", 32'(ctl_wdata), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_rd_pending", 32'(rd_pending), 0);
        check("rst_err_orphan", 32'(err_orphan), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);

        // Single write from port 1
        ctl_ready = 1'b1;
        set_port(1, 1'b1, 1'b1, 25'h0000100, 16'hA5A5);
        #1;
        check("wr_ready", 32'(req_ready), 32'b010);
        next_cycle();
        req_valid = '0;
        check("wr_ctl_valid", 32'(ctl_valid), 1);
        check("wr_ctl_we", 32'(ctl_we), 1);
        check("wr_ctl_addr", 32'(ctl_addr), 32'h100);
        check("wr_ctl_wdata", 32'(ctl_wdata), 32'hA5A5);
        check("wr_grant_id", 32'(grant_id), 1);
        next_cycle();
        check("wr_ctl_valid_drop", 32'(ctl_valid), 0);

        // Round-robin reads from ports 1 and 2, data returned 2 cycles after each command
        do_reset();
        ctl_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rdv[i] = 1'b0;
            rdd[i] = '0;
        end
        set_port(1, 1'b1, 1'b0, 25'h111, '0);
        set_port(2, 1'b1, 1'b0, 25'h222, '0);
        n_rsp = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) req_valid = '0;
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rr_rsp_extra", 32'(rsp_valid), 0);
                end else begin
                    exp_p = exp_q.pop_front();
                    check("rr_rsp_port", 32'(rsp_valid), 32'(1) << exp_p);
                    check("rr_rsp_data", 32'(rsp_data), (exp_p == 1) ? 32'h111 : 32'h222);
                    n_rsp++;
                end
            end
            if (ctl_valid && !ctl_we) begin
                rdv[c+2] = 1'b1;
                rdd[c+2] = ctl_addr[15:0];
            end
            ctl_rdata_valid = rdv[c];
            ctl_rdata       = rdd[c];
            check("rr_pending_le4", 32'(rd_pending <= 3'd4), 1);
            #1;
            if (c < 12) begin
                exp_p = (c % 2 == 0) ? 1 : 2;
                check("rr_grant", 32'(req_ready), 32'(1) << exp_p);
                exp_q.push_back(exp_p);
            end else begin
                check("rr_idle", 32'(req_ready), 0);
            end
            next_cycle();
        end
        ctl_rdata_valid = 1'b0;
        check("rr_rsp_count", 32'(n_rsp), 12);
        check("rr_rsp_left", 32'(exp_q.size()), 0);

        // Port 0 streams writes; port 2 read is forced through after 64 waiting cycles
        do_reset();
        ctl_ready = 1'b1;
        set_port(0, 1'b1, 1'b1, 25'h0AA, 16'h00AA);
        set_port(2, 1'b1, 1'b0, 25'h2BB, '0);
        for (int c = 0; c < 70; c++) begin
            if (c == 65) check("starve_ctl_id", 32'(grant_id), 2);
            #1;
            if (c == 64) check("starve_grant_p2", 32'(req_ready), 32'b100);
            else         check("starve_p0", 32'(req_ready), 32'b001);
            next_cycle();
            if (c == 64) req_valid[2] = 1'b0;
        end

        // Tag FIFO full blocks reads but not writes; a pop frees a tag in the same cycle
        do_reset();
        ctl_ready = 1'b1;
        set_port(1, 1'b1, 1'b0, 25'h101, '0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("tag_fill", 32'(req_ready), 32'b010);
            next_cycle();
        end
        check("tag_pending4", 32'(rd_pending), 4);
        set_port(2, 1'b1, 1'b1, 25'h202, 16'h0202);
        #1;
        check("tag_full_write", 32'(req_ready), 32'b100);
        next_cycle();
        req_valid[2] = 1'b0;
        #1;
        check("tag_full_block", 32'(req_ready), 0);
        next_cycle();
        ctl_rdata_valid = 1'b1;
        ctl_rdata       = 16'hBEEF;
        #1;
        check("tag_pop_grant", 32'(req_ready), 32'b010);
        next_cycle();
        ctl_rdata_valid = 1'b0;
        req_valid[1]    = 1'b0;
        check("tag_rsp_port", 32'(rsp_valid), 32'b010);
        check("tag_rsp_data", 32'(rsp_data), 32'hBEEF);
        check("tag_pending_after", 32'(rd_pending), 4);

        // Backpressure: command held stable, no grants, immediate accept on release
        do_reset();
        ctl_ready = 1'b0;
        set_port(1, 1'b1, 1'b1, 25'h055, 16'h1234);
        #1;
        check("bp_first", 32'(req_ready), 32'b010);
        next_cycle();
        req_valid[1] = 1'b0;
        set_port(2, 1'b1, 1'b1, 25'h066, 16'h5678);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(ctl_valid), 1);
            check("bp_addr", 32'(ctl_addr), 32'h55);
            check("bp_wdata", 32'(ctl_wdata), 32'h1234);
            check("bp_grant", 32'(grant_id), 1);
            #1;
            check("bp_no_ready", 32'(req_ready), 0);
            next_cycle();
        end
        ctl_ready = 1'b1;
        #1;
        check("bp_release", 32'(req_ready), 32'b100);
        next_cycle();
        req_valid[2] = 1'b0;
        check("bp_next_valid", 32'(ctl_valid), 1);
        check("bp_next_addr", 32'(ctl_addr), 32'h66);
        check("bp_next_wdata", 32'(ctl_wdata), 32'h5678);
        check("bp_next_grant", 32'(grant_id), 2);
        next_cycle();
        check("bp_drain", 32'(ctl_valid), 0);

        // Orphan read data, then reset with two reads outstanding
        do_reset();
        ctl_ready       = 1'b1;
        ctl_rdata_valid = 1'b1;
        ctl_rdata       = 16'hDEAD;
        next_cycle();
        ctl_rdata_valid = 1'b0;
        check("orphan_flag", 32'(err_orphan), 1);
        check("orphan_no_rsp", 32'(rsp_valid), 0);
        next_cycle();
        check("orphan_sticky", 32'(err_orphan), 1);
        set_port(1, 1'b1, 1'b0, 25'h010, '0);
        next_cycle();
        req_valid[1] = 1'b0;
        set_port(2, 1'b1, 1'b0, 25'h020, '0);
        next_cycle();
        req_valid[2] = 1'b0;
        check("pre_rst_pending", 32'(rd_pending), 2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("post_rst_pending", 32'(rd_pending), 0);
        check("post_rst_orphan", 32'(err_orphan), 0);
        check("post_rst_ctl_valid", 32'(ctl_valid), 0);
        check("post_rst_rsp", 32'(rsp_valid), 0);
        for (int c = 0; c < 4; c++) begin
            ctl_rdata_valid = (c < 2);
            ctl_rdata       = 16'h00C0 + 16'(c);
            next_cycle();
            check("rst_dropped_rsp", 32'(rsp_valid), 0);
        end
        ctl_rdata_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
